// File: rtl/conv_pkg.sv
// Shared types, the tap-count helper, the FSM state enum and the
// saturation / ReLU helpers for the convolution MAC engine.
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    localparam int DEF_OUT_W  = 16;

    typedef logic signed [DEF_DATA_W-1:0] act_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;
    typedef logic signed [DEF_OUT_W-1:0]  out_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Taps per window beat for a square kernel.
    function automatic int kk_of(input int ksize);
        return ksize * ksize;
    endfunction

    // Negative values become zero.
    function automatic logic signed [63:0] relu_fn(input logic signed [63:0] x);
        return (x < 64'sd0) ? 64'sd0 : x;
    endfunction

    // Clamp to the signed range of an out_w-bit result.
    function automatic logic signed [63:0] sat_fn(input logic signed [63:0] x,
                                                  input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/conv_pe.sv
// KK-tap signed multiply plus adder with a registered, stall-enabled
// partial-sum output.
module conv_pe
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KK     = 9,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic [KK*DATA_W-1:0]    i_act,
    input  logic [KK*DATA_W-1:0]    i_wgt,
    output logic signed [ACC_W-1:0] o_psum
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] w_prod_p0 [KK];
    logic signed [ACC_W-1:0]  w_sum_p0;
    logic signed [ACC_W-1:0]  r_psum_p1;

    for (genvar j = 0; j < KK; j++) begin : g_mul
        assign w_prod_p0[j] = $signed(i_act[j*DATA_W +: DATA_W]) *
                              $signed(i_wgt[j*DATA_W +: DATA_W]);
    end

    // Sum all full-precision products after sign extension to ACC_W.
    always_comb begin
        w_sum_p0 = '0;
        for (int j = 0; j < KK; j++)
            w_sum_p0 = w_sum_p0 + ACC_W'(w_prod_p0[j]);
    end

    // Stage 0 -> 1: capture the partial sum only when a beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_psum_p1 <= '0;
        else if (i_en)
            r_psum_p1 <= w_sum_p0;
    end

    assign o_psum = r_psum_p1;

endmodule

// File: rtl/conv_stream_mac.sv
// Streaming convolution engine: one KSIZE*KSIZE*CH signed dot product plus
// bias per output pixel, saturated to OUT_W bits.
// Optional feature macro: CONV_RELU_EN (clip negative results to zero).
module conv_stream_mac
    import conv_pkg::*;
#(
    parameter int  DATA_W  = 8,
    parameter int  KSIZE   = 3,
    parameter int  CH      = 1,
    parameter int  ACC_W   = 24,
    parameter int  OUT_W   = 16,
    parameter int  NUM_PIX = 676,
    localparam int KK      = kk_of(KSIZE),
    localparam int NW      = KK * CH,
    localparam int ADDR_W  = $clog2(NW + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [ADDR_W-1:0]    cfg_addr,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [KK*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_last
);

    localparam int               CH_W      = (CH > 1) ? $clog2(CH) : 1;
    localparam int               PIX_W     = $clog2(NUM_PIX + 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CH - 1);
    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(NUM_PIX - 1);
    localparam logic [PIX_W-1:0]  PIX_END   = PIX_W'(NUM_PIX);
    localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(NW);

    state_t                   r_state, w_state_next;
    logic signed [DATA_W-1:0] r_wgt [NW];
    logic signed [DATA_W-1:0] r_bias;
    logic [CH_W-1:0]          r_ch;
    logic [PIX_W-1:0]         r_pix;
    logic [KK*DATA_W-1:0]     w_wsel;
    logic                     w_idle, w_out_free, w_in_hs, w_out_hs, w_ch_last;
    logic                     r_vld_p1, r_first_p1, r_last_p1, r_lastpix_p1;
    logic signed [ACC_W-1:0]  w_psum_p1, w_sum_p1, r_acc_p2;
    logic signed [63:0]       w_res_p1, w_pre_p1, w_sat_p1;
    logic [OUT_W-1:0]         r_out_data_p2;
    logic                     r_out_valid_p2, r_out_last_p2, r_done;

    assign w_idle     = (r_state == IDLE);
    assign w_out_free = !r_out_valid_p2 || out_ready;
    assign w_ch_last  = (r_ch == CH_LAST);
    assign in_ready   = (r_state == RUN) && (r_pix < PIX_END) && w_out_free;
    assign w_in_hs    = in_valid && in_ready;
    assign w_out_hs   = r_out_valid_p2 && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // IDLE -> RUN on start; RUN -> IDLE on the frame's final output handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_out_hs && r_out_last_p2) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Weight and bias registers, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) r_wgt[i] <= '0;
            r_bias <= '0;
        end else if (w_idle && cfg_we) begin
            if (cfg_addr < BIAS_ADDR)
                r_wgt[cfg_addr] <= cfg_data;
            else if (cfg_addr == BIAS_ADDR)
                r_bias <= cfg_data;
        end
    end

    // Channel and accepted-pixel counters, cleared when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_pix <= '0;
        end else if (w_idle && start) begin
            r_ch  <= '0;
            r_pix <= '0;
        end else if (w_in_hs) begin
            r_ch <= w_ch_last ? '0 : r_ch + 1'b1;
            if (w_ch_last) r_pix <= r_pix + 1'b1;
        end
    end

    // Pick the weight row for the channel of the incoming beat.
    always_comb begin
        w_wsel = '0;
        for (int j = 0; j < KK; j++)
            w_wsel[j*DATA_W +: DATA_W] = r_wgt[int'(r_ch) * KK + j];
    end

    conv_pe #(
        .DATA_W (DATA_W),
        .KK     (KK),
        .ACC_W  (ACC_W)
    ) u_pe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_in_hs),
        .i_act  (in_data),
        .i_wgt  (w_wsel),
        .o_psum (w_psum_p1)
    );

    // Stage 0 -> 1: beat tags travel with the registered partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1     <= 1'b0;
            r_first_p1   <= 1'b0;
            r_last_p1    <= 1'b0;
            r_lastpix_p1 <= 1'b0;
        end else if (w_out_free) begin
            r_vld_p1 <= w_in_hs;
            if (w_in_hs) begin
                r_first_p1   <= (r_ch == '0);
                r_last_p1    <= w_ch_last;
                r_lastpix_p1 <= w_ch_last && (r_pix == PIX_LAST);
            end
        end
    end

    // Channel accumulation, bias, optional ReLU and saturation.
    always_comb begin
        w_sum_p1 = (r_first_p1 ? '0 : r_acc_p2) + w_psum_p1;
        w_res_p1 = 64'(w_sum_p1) + 64'(r_bias);
`ifdef CONV_RELU_EN
        w_pre_p1 = relu_fn(w_res_p1);
`else
        w_pre_p1 = w_res_p1;
`endif
        w_sat_p1 = sat_fn(w_pre_p1, OUT_W);
    end

    // Stage 1 -> 2: accumulate inner channels, load the output on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_p2       <= '0;
            r_out_valid_p2 <= 1'b0;
            r_out_data_p2  <= '0;
            r_out_last_p2  <= 1'b0;
        end else if (w_out_free) begin
            if (r_vld_p1 && r_last_p1) begin
                r_out_valid_p2 <= 1'b1;
                r_out_data_p2  <= OUT_W'(w_sat_p1);
                r_out_last_p2  <= r_lastpix_p1;
            end else begin
                r_out_valid_p2 <= 1'b0;
                r_out_last_p2  <= 1'b0;
            end
            if (r_vld_p1 && !r_last_p1)
                r_acc_p2 <= w_sum_p1;
        end
    end

    // Frame-complete pulse, one cycle after the final output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_done <= 1'b0;
        else
            r_done <= w_out_hs && r_out_last_p2;
    end

    assign busy      = (r_state == RUN);
    assign done      = r_done;
    assign out_valid = r_out_valid_p2;
    assign out_data  = r_out_data_p2;
    assign out_last  = r_out_last_p2;

endmodule

// File: tb/tb_conv_stream_mac.sv
// Bench for conv_stream_mac with KSIZE=3, CH=2, NUM_PIX=4.
module tb_conv_stream_mac;

    localparam int DW  = 8;
    localparam int KS  = 3;
    localparam int CHN = 2;
    localparam int AW  = 24;
    localparam int OW  = 16;
    localparam int NP  = 4;
    localparam int KK  = KS * KS;
    localparam int NW  = KK * CHN;
    localparam int ADW = $clog2(NW + 1);

`ifdef CONV_RELU_EN
    localparam int NEG_EXP    = 0;
    localparam int SATNEG_EXP = 0;
`else
    localparam int NEG_EXP    = -900;
    localparam int SATNEG_EXP = -32768;
`endif

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [ADW-1:0]    cfg_addr;
    logic [DW-1:0]     cfg_data;
    logic              start;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic [KK*DW-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              out_last;

    conv_stream_mac #(
        .DATA_W  (DW),
        .KSIZE   (KS),
        .CH      (CHN),
        .ACC_W   (AW),
        .OUT_W   (OW),
        .NUM_PIX (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: programmed weights/bias, window contents, expected pixels.
    int m_w [NW];
    int m_bias;
    int win [NP][CHN][KK];
    int exp_q [NP];

    typedef struct {
        string name;
        int    x0, w0, x1, w1, bias, exp_val;
        int    stall_at, stall_len, poke, timing;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Dot product over every tap of every channel, plus bias, then clamp.
    function automatic int model_pixel(input int p);
        int s;
        s = m_bias;
        for (int c = 0; c < CHN; c++)
            for (int j = 0; j < KK; j++)
                s += win[p][c][j] * m_w[c*KK + j];
`ifdef CONV_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic fill_uniform(input int x0, input int x1);
        for (int p = 0; p < NP; p++)
            for (int j = 0; j < KK; j++) begin
                win[p][0][j] = x0;
                win[p][1][j] = x1;
            end
    endtask

    task automatic fill_random_win();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < CHN; c++)
                for (int j = 0; j < KK; j++)
                    win[p][c][j] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic randomize_weights();
        for (int i = 0; i < NW; i++) m_w[i] = int'($urandom_range(0, 255)) - 128;
        m_bias = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic model_all();
        for (int p = 0; p < NP; p++) exp_q[p] = model_pixel(p);
    endtask

    // Write all weights, poke the unused addresses, then write bias together with start.
    task automatic program_all();
        for (int i = 0; i < NW; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = ADW'(i); cfg_data = DW'(m_w[i]);
        end
        for (int a = NW + 1; a < (1 << ADW); a++) begin
            @(negedge clk);
            cfg_addr = ADW'(a); cfg_data = DW'($urandom_range(0, 255));
        end
        @(negedge clk);
        cfg_addr = ADW'(NW); cfg_data = DW'(m_bias); start = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Stream one frame and check every result; returns the number of results seen.
    task automatic run_frame(input int stall_at, input int stall_len, input bit rand_stall,
                             input int poke, input int abort_after, input bit timing,
                             output int got);
        int beat, cyc, acc_cyc, first_acc, last_acc, first_vld, done_seen;
        beat = 0; got = 0; cyc = 0; acc_cyc = -1; first_acc = -1; last_acc = -1;
        first_vld = -1; done_seen = 0;
        while (got < NP && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
            else            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            cfg_we = (poke > 0) && (cyc == poke || cyc == poke + 1);
            cfg_addr = (cyc == poke) ? ADW'(0) : ADW'(NW);
            cfg_data = DW'(77);
            if (beat < NP * CHN) begin
                in_valid = 1'b1;
                for (int j = 0; j < KK; j++)
                    in_data[j*DW +: DW] = DW'(win[beat / CHN][beat % CHN][j]);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 1) chk("busy_run", int'(busy), 1);
            if (done) done_seen++;
            if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (beat == CHN - 1) acc_cyc = cyc;
                beat++;
            end
            if (out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                chk("out_data", int'($signed(out_data)), exp_q[got]);
                if (out_ready) begin
                    chk("out_last", int'(out_last), int'(got == NP - 1));
                    got++;
                    if (got == abort_after) break;
                end
            end
        end
        in_valid = 1'b0; cfg_we = 1'b0;
        if (abort_after == 0) begin
            out_ready = 1'b1;
            chk("frame_complete", got, NP);
            chk("done_early", done_seen, 0);
            if (timing) begin
                chk("latency", first_vld - acc_cyc, 2);
                chk("throughput", last_acc - first_acc, NP * CHN - 1);
            end
            @(negedge clk);
            chk("done_pulse", int'(done), 1);
            chk("busy_after", int'(busy), 0);
            @(negedge clk);
            chk("done_single", int'(done), 0);
            chk("out_valid_idle", int'(out_valid), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_done"},      int'(done), 0);
        chk({tag, "_in_ready"},  int'(in_ready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_data"},  int'(out_data), 0);
        chk({tag, "_out_last"},  int'(out_last), 0);
    endtask

    initial begin
        int got;
        rst_n = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        tbl[0] = '{"k3_ones",   3,    1,    0,    0,    2,    29,         0, 0, 0, 1};
        tbl[1] = '{"neg",       100,  -1,   0,    0,    0,    NEG_EXP,    0, 0, 0, 0};
        tbl[2] = '{"sat_pos",   127,  127,  127,  127,  127,  32767,      0, 0, 0, 0};
        tbl[3] = '{"sat_neg",   127,  -128, 127,  -128, -128, SATNEG_EXP, 0, 0, 0, 0};
        tbl[4] = '{"ch2_stall", 1,    1,    2,    2,    -5,   40,         4, 5, 3, 0};

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Directed table: uniform windows, constant expected pixels.
        for (int t = 0; t < 5; t++) begin
            for (int j = 0; j < KK; j++) begin
                m_w[j]      = tbl[t].w0;
                m_w[KK + j] = tbl[t].w1;
            end
            m_bias = tbl[t].bias;
            fill_uniform(tbl[t].x0, tbl[t].x1);
            for (int p = 0; p < NP; p++) exp_q[p] = tbl[t].exp_val;
            program_all();
            run_frame(tbl[t].stall_at, tbl[t].stall_len, 1'b0, tbl[t].poke, 0,
                      tbl[t].timing[0], got);
        end

        // Writes made during the stalled frame must not have landed.
        do_start();
        run_frame(0, 0, 1'b0, 0, 0, 1'b0, got);

        // Random weights, windows and back-pressure against the model.
        for (int f = 0; f < 6; f++) begin
            randomize_weights();
            fill_random_win();
            model_all();
            program_all();
            run_frame(0, 0, 1'b1, 0, 0, 1'b0, got);
        end

        // Reset mid-frame after two pixels.
        randomize_weights();
        fill_random_win();
        model_all();
        program_all();
        run_frame(0, 0, 1'b0, 0, 2, 1'b0, got);
        chk("abort_count", got, 2);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk); rst_n = 1'b1;

        // Weights and bias were cleared, so an unprogrammed frame yields zeros.
        for (int i = 0; i < NW; i++) m_w[i] = 0;
        m_bias = 0;
        fill_random_win();
        model_all();
        do_start();
        run_frame(0, 0, 1'b0, 0, 0, 1'b0, got);

        // Reprogrammed frame restarts cleanly at pixel 0.
        randomize_weights();
        fill_random_win();
        model_all();
        program_all();
        run_frame(0, 0, 1'b0, 0, 0, 1'b1, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d",
                 n_tests, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/conv_stream_mac.md
# conv_stream_mac

Streaming, parametrised convolution engine for the CNN accelerator. It computes one output pixel per im2col window, where each window is a KSIZE×KSIZE×CH signed dot product with a programmable bias, followed by optional ReLU and signed saturation. Window data arrives on a valid/ready stream from the im2col buffer, and results leave on a valid/ready stream to the pooling/writeback stage. Weights and bias are register-programmed while the block is idle.

## Interface
- DATA_W, 8: width of activations, weights and bias (signed two's complement)
- KSIZE, 3: kernel side; KK = KSIZE*KSIZE taps per beat
- CH, 1: input channels accumulated per output pixel
- ACC_W, 24: accumulator width (signed)
- OUT_W, 16: result width (signed, saturated)
- NUM_PIX, 676: output pixels per frame
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  weight/bias write strobe (honoured in IDLE only)
- cfg_addr  in  $clog2(KK*CH+1)  index c*KK+j for weights; KK*CH selects bias
- cfg_data  in  DATA_W  write data
- start  in  1  begin frame (honoured in IDLE only)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on the final output handshake
- in_valid / in_ready  in / out  1  window-beat handshake
- in_data  in  KK*DATA_W  one channel of one window; tap j at bits [j*DATA_W +: DATA_W]
- out_valid / out_ready  out / in  1  result handshake
- out_data  out  OUT_W  result pixel
- out_last  out  1  high with the frame's final pixel

## Operation
- States: IDLE → RUN on start; RUN → IDLE on the handshake of pixel NUM_PIX-1, which also pulses done.
- In IDLE, cfg_we writes weight[cfg_addr] or the bias. Out-of-range addresses are ignored. Writes in RUN are ignored. start in RUN is ignored.
- Beats per pixel are channel-ordered (c = 0..CH-1). A channel counter wraps at CH-1, and a pixel counter counts accepted pixels.
- Stage 1 (PE): psum = Σ in_data[j]*weight[c*KK+j], full precision, sign-extended to ACC_W, registered.
- Stage 2: acc = (c==0 ? psum : acc+psum). On the last channel, result = acc+psum+sext(bias) → optional ReLU → clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] → output register.
- ACC_W wrap is not checked. Parameters must give ACC_W ≥ 2*DATA_W + $clog2(KK*CH) + 1.
- in_ready = RUN && pixels_accepted < NUM_PIX && the pipeline can advance. It is low while the output register is full and out_ready is low, or while stage 1 holds a last-channel beat that cannot advance.
- The pipeline is elastic: there are no bubbles while out_ready stays high, and no beat or result is ever dropped or duplicated.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, out_last=0, all weights and bias 0, counters 0, state IDLE.
- in_ready may rise in the cycle after start is sampled.
- Latency: last-channel beat accepted at cycle t → out_valid at t+2.
- Throughput: 1 beat/cycle, so one pixel per CH cycles.
- out_data and out_last hold stable while out_valid && !out_ready.
- done is asserted in the cycle after the final handshake, together with busy=0.
- An rst_n assertion mid-frame immediately clears all state, including weights. A new frame needs reprogramming.
- A config write and start in the same IDLE cycle: the write takes effect and RUN begins next cycle with the new value.

## Configuration
- CONV_RELU_EN defined: a negative pre-saturation result becomes 0 before clamping.
- CONV_RELU_EN undefined: results pass signed to the saturator, and negative outputs are possible.

## Structure
- Shared package conv_pkg holds:
  - typedefs for the activation, accumulator and output types
  - the KK localparam helper
  - the state enum {IDLE, RUN}
  - saturation and ReLU functions
- Sub-module conv_pe: KK-tap signed multiply plus adder tree with a registered output and a stall enable. It is instantiated once.

## Test plan
- KSIZE=3, CH=1: weights all 1, bias 2, window all 3 → out_data=29, latency 2 cycles.
- Weights all -1, window all 100, bias 0 → -900 without CONV_RELU_EN; 0 with it.
- Weights all 127, window all 127, OUT_W=16 → saturates to 32767. Weights all -128 → saturates to -32768.
- CH=2: channel 0 taps 1 with weights 1, channel 1 taps 2 with weights 2, bias -5 → 9+36-5 = 40. One pixel per 2 cycles at full rate.
- NUM_PIX=4, out_ready low for 5 cycles mid-frame:
  - in_ready drops and all 4 results arrive in order.
  - out_last is on the 4th result and done pulses once.
  - A cfg write during RUN has no effect.
- rst_n low after 2 pixels → all outputs return to reset values at once. After reprogramming and start, the frame restarts cleanly at pixel 0.
